// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: hilo_op bit positions,
// divider sizing, FSM state encoding and a two's-complement sign helper.
package hilo_mdu_pkg;

   localparam int HILO_MFHI = 8;
   localparam int HILO_MFLO = 7;
   localparam int HILO_MTHI = 6;
   localparam int HILO_MTLO = 5;
   localparam int HILO_MULT = 4;
   localparam int HILO_MULTU = 3;
   localparam int HILO_DIV = 2;
   localparam int HILO_DIVU = 1;
   localparam int HILO_MUL = 0;
   localparam int HILO_OP_W = 9;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// EX-stage bundle between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface hilo_mdu_if;

   logic                                en;
   logic                                flush;
   logic [hilo_mdu_pkg::HILO_OP_W-1:0]  hilo_op;
   logic [31:0]                         rs_val;
   logic [31:0]                         rt_val;
   logic                                stallreq;
   logic [31:0]                         result;
   logic [31:0]                         hi_o;
   logic [31:0]                         lo_o;

   modport master (
      output en, flush, hilo_op, rs_val, rt_val,
      input  stallreq, result, hi_o, lo_o
   );

   modport slave (
      input  en, flush, hilo_op, rs_val, rt_val,
      output stallreq, result, hi_o, lo_o
   );

endinterface

// File: rtl/hilo_mdu_div_radix2.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, with the
// sign fix-up applied on the way out. Owns the iteration counter and remainder path.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   DIV_IDLE | waiting; a start latches operand magnitudes and signs
//   DIV_BUSY | shifting one dividend bit per cycle into the partial remainder
//   DIV_DONE | quotient/remainder valid for one cycle; held start is ignored
module hilo_mdu_div_radix2
   import hilo_mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        flush,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      dvd;
   logic [31:0]      dvs;
   logic [31:0]      prem;
   logic             q_neg;
   logic             r_neg;
   logic [32:0]      shifted;
   logic [32:0]      diff;
   logic             ge;

   // dvd doubles as the quotient register: dividend bits leave the top as quotient bits enter the bottom
   assign shifted = {prem, dvd[31]};
   assign diff    = shifted - {1'b0, dvs};
   assign ge      = shifted >= {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_IDLE: if (start) state_nxt = DIV_BUSY;
         DIV_BUSY: if (cnt == CNT_W'(DIV_ITERS - 1)) state_nxt = DIV_DONE;
         DIV_DONE: state_nxt = DIV_IDLE;
         default:  state_nxt = DIV_IDLE;
      endcase
      if (flush) state_nxt = DIV_IDLE;
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      if (!flush) begin
         case (state)
            DIV_IDLE: busy = start;
            DIV_BUSY: busy = 1'b1;
            DIV_DONE: done = 1'b1;
            default:  busy = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         prem  <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  dvd   <= apply_sign(a, signed_div & a[31]);
                  dvs   <= apply_sign(b, signed_div & b[31]);
                  prem  <= '0;
                  cnt   <= '0;
                  q_neg <= signed_div & (a[31] ^ b[31]);
                  r_neg <= signed_div & a[31];
               end
            end
            DIV_BUSY: begin
               prem <= ge ? diff[31:0] : shifted[31:0];
               dvd  <= {dvd[30:0], ge};
               cnt  <= cnt + 1'b1;
            end
            default: cnt <= '0;
         endcase
      end
   end

   assign quot = apply_sign(dvd, q_neg);
   assign rem  = apply_sign(prem, r_neg);

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit: HI/LO registers, single-cycle multiplier,
// result mux and pipeline stall request around the iterative divider.
module hilo_mdu
   import hilo_mdu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   hilo_mdu_if.slave  bus
);

   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        live;
   logic        div_start;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   assign live      = bus.en & ~bus.flush;
   assign div_start = live & (bus.hilo_op[HILO_DIV] | bus.hilo_op[HILO_DIVU])
                      & (bus.rt_val != 32'd0);

   assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val})
                 * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
   assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

   hilo_mdu_div_radix2 u_div (
      .clk        (clk),
      .rst        (rst),
      .start      (div_start),
      .signed_div (bus.hilo_op[HILO_DIV]),
      .flush      (bus.flush),
      .a          (bus.rs_val),
      .b          (bus.rt_val),
      .busy       (div_busy),
      .done       (div_done),
      .quot       (div_quot),
      .rem        (div_rem)
   );

   // In the divider's DONE cycle the held instruction is the divide itself, so no other write competes
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (div_done) begin
         hi_q <= div_rem;
         lo_q <= div_quot;
      end else if (live) begin
         if (bus.hilo_op[HILO_MULT]) begin
            hi_q <= prod_s[63:32];
            lo_q <= prod_s[31:0];
         end else if (bus.hilo_op[HILO_MULTU]) begin
            hi_q <= prod_u[63:32];
            lo_q <= prod_u[31:0];
         end else if (bus.hilo_op[HILO_MTHI]) begin
            hi_q <= bus.rs_val;
         end else if (bus.hilo_op[HILO_MTLO]) begin
            lo_q <= bus.rs_val;
         end
      end
   end

   always_comb begin
      bus.result = '0;
      if (live) begin
         if (bus.hilo_op[HILO_MFHI])      bus.result = hi_q;
         else if (bus.hilo_op[HILO_MFLO]) bus.result = lo_q;
         else if (bus.hilo_op[HILO_MUL])  bus.result = prod_s[31:0];
      end
   end

   assign bus.stallreq = div_busy;
   assign bus.hi_o     = hi_q;
   assign bus.lo_o     = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: the driver queues hand-computed expectations,
// the monitor checks each instruction as it leaves EX (en high, stallreq low).
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   hilo_mdu_if bus();

   hilo_mdu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [8:0] OP_MFHI  = 9'(1) << HILO_MFHI;
   localparam logic [8:0] OP_MFLO  = 9'(1) << HILO_MFLO;
   localparam logic [8:0] OP_MTHI  = 9'(1) << HILO_MTHI;
   localparam logic [8:0] OP_MTLO  = 9'(1) << HILO_MTLO;
   localparam logic [8:0] OP_MULT  = 9'(1) << HILO_MULT;
   localparam logic [8:0] OP_MULTU = 9'(1) << HILO_MULTU;
   localparam logic [8:0] OP_DIV   = 9'(1) << HILO_DIV;
   localparam logic [8:0] OP_DIVU  = 9'(1) << HILO_DIVU;
   localparam logic [8:0] OP_MUL   = 9'(1) << HILO_MUL;

   typedef struct {
      string       name;
      bit          chk_res;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall;
   } exp_t;

   exp_t sb[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   stall_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
      end
   endtask

   // Monitor: count stall cycles, then on retirement compare result now and HI/LO after the edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            stall_cnt = 0;
         end else if (bus.en && bus.stallreq) begin
            stall_cnt++;
         end else if (bus.en) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_retire: got op %09b, expected none", bus.hilo_op);
            end else begin
               e = sb.pop_front();
               check({e.name, "/stall_cycles"}, 32'(stall_cnt), 32'(e.stall));
               if (e.chk_res) check({e.name, "/result"}, bus.result, e.res);
               stall_cnt = 0;
               @(posedge clk);
               #1;
               check({e.name, "/hi"}, bus.hi_o, e.hi);
               check({e.name, "/lo"}, bus.lo_o, e.lo);
            end
         end
      end
   end

   task automatic issue(input string nm, input logic [8:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input bit chk_res, input logic [31:0] res,
                        input logic [31:0] hi, input logic [31:0] lo, input int stall);
      exp_t e;
      int   guard;
      e.name = nm; e.chk_res = chk_res; e.res = res; e.hi = hi; e.lo = lo; e.stall = stall;
      sb.push_back(e);
      bus.en      = 1'b1;
      bus.flush   = 1'b0;
      bus.hilo_op = op;
      bus.rs_val  = rs;
      bus.rt_val  = rt;
      guard = 0;
      @(negedge clk);
      while (bus.stallreq && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s/timeout: got stallreq=1 after %0d cycles, expected release", nm, guard);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.en      = 1'b0;
      bus.flush   = 1'b0;
      bus.hilo_op = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got no finish by 200000ns, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bus.en      = 1'b0;
      bus.flush   = 1'b0;
      bus.hilo_op = '0;
      bus.rs_val  = '0;
      bus.rt_val  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset/stallreq", {31'd0, bus.stallreq}, 32'd0);
      check("reset/result", bus.result, 32'd0);
      check("reset/hi", bus.hi_o, 32'd0);
      check("reset/lo", bus.lo_o, 32'd0);

      issue("mfhi_reset", OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0);
      issue("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      issue("multu_max_x2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, 32'h0, 32'h1, 32'hFFFFFFFE, 0);
      issue("mul_7xm6", OP_MUL, 32'd7, 32'hFFFFFFFA, 1, 32'hFFFFFFD6, 32'h1, 32'hFFFFFFFE, 0);
      issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 1, 32'h0, 32'h1, 32'hFFFFFFFD, 33);
      issue("mflo_after_div", OP_MFLO, 32'h0, 32'h0, 1, 32'hFFFFFFFD, 32'h1, 32'hFFFFFFFD, 0);
      issue("divu_max_16", OP_DIVU, 32'hFFFFFFFF, 32'd16, 1, 32'h0, 32'hF, 32'h0FFFFFFF, 33);
      issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h0, 32'h80000000, 33);
      issue("div_by_zero", OP_DIV, 32'd5, 32'd0, 1, 32'h0, 32'h0, 32'h80000000, 0);
      issue("mthi", OP_MTHI, 32'h1234, 32'h0, 1, 32'h0, 32'h1234, 32'h80000000, 0);
      issue("mfhi", OP_MFHI, 32'h0, 32'h0, 1, 32'h1234, 32'h1234, 32'h80000000, 0);
      issue("mtlo", OP_MTLO, 32'hCAFEF00D, 32'h0, 1, 32'h0, 32'h1234, 32'hCAFEF00D, 0);
      issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      idle();
      issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1, 32'h0, 32'h2, 32'hE, 33);

      // Divide aborted by flush in its tenth BUSY cycle
      e.name = "divu_flushed"; e.chk_res = 0; e.res = '0; e.hi = 32'h2; e.lo = 32'hE; e.stall = 10;
      sb.push_back(e);
      bus.en = 1'b1; bus.flush = 1'b0; bus.hilo_op = OP_DIVU;
      bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush/stallreq", {31'd0, bus.stallreq}, 32'd0);
      @(posedge clk);
      #1;
      idle();
      issue("mfhi_post_flush", OP_MFHI, 32'h0, 32'h0, 1, 32'h2, 32'h2, 32'hE, 0);
      issue("divu_post_flush", OP_DIVU, 32'd100, 32'd9, 1, 32'h0, 32'h1, 32'hB, 33);

      // Divide aborted by reset mid-iteration
      bus.en = 1'b1; bus.flush = 1'b0; bus.hilo_op = OP_DIVU;
      bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.hilo_op = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_abort/stallreq", {31'd0, bus.stallreq}, 32'd0);
      issue("mfhi_post_rst", OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0);
      issue("mflo_post_rst", OP_MFLO, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0);

      repeat (4) idle();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
